next_pc_unit: RTL
=================

Name: next_pc_unit

Overview:
- Program-counter register plus next-address selection for the pipelined core.
- Resolves branch and jump outcomes forwarded from the EX/MA stage and selects the next fetch address.
- Adds what the current address mux lacks: an owned PC register with stall, registered redirect hold, bne/bge modes, misaligned-target trap, and parametrised width and vectors.
- Sits between the EXMA pipeline register and instruction fetch; drives the fetch address and the IF/ID flush.

Parameters:
- ADDR_W, 32, width of every address port and of the PC register.
- RESET_VECTOR, 32'h0000_0000, PC value after reset and target of selector code 7.
- TRAP_VECTOR, 32'h0000_0100, redirect target when a taken target is misaligned.
- INSTR_BYTES, 4, sequential increment and required target alignment.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StallIn  input  1  hazard stall from the hazard unit; PC holds while high.
- ValidIn  input  1  the EXMA instruction is valid; qualifies SelectorIn.
- SelectorIn  input  3  control-flow mode from EXMA.
- LessIn  input  1  ALU less-than result from EXMA.
- ZeroIn  input  1  ALU zero result from EXMA.
- PCRelAddrIn  input  ADDR_W  PC-relative target from EXMA.
- RegRelAddrIn  input  ADDR_W  rs1+imm target from EXMA.
- PCOut  output  ADDR_W  registered fetch address.
- FlushOut  output  1  combinational flush of IF/ID in the cycle a redirect is decided.
- MisalignOut  output  1  registered one-cycle pulse: a taken target was misaligned.
- TakenCountOut  output  16  taken-redirect counter (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - PCOut=RESET_VECTOR; MisalignOut=0; pending-redirect flag and register cleared; TakenCountOut=0.
  - FlushOut forced 0 while rst_n is low.
- Selector decode, when ValidIn=1:
  - 0: sequential, never taken.
  - 1: blt, taken if LessIn.
  - 2: beq, taken if ZeroIn.
  - 3: jal, always taken to PCRelAddrIn.
  - 4: jalr, always taken to {RegRelAddrIn[ADDR_W-1:1],1'b0}.
  - 5: bne, taken if !ZeroIn.
  - 6: bge, taken if !LessIn.
  - 7: soft reset, always taken to RESET_VECTOR.
- Modes 1, 2, 5 and 6 use PCRelAddrIn as the target. ValidIn=0 means not taken.
- Sequential next address = PCOut + INSTR_BYTES, modulo 2^ADDR_W; wrap from all-ones is silent.
- Misalignment check:
  - A taken target with target % INSTR_BYTES != 0 is misaligned.
  - The effective target becomes TRAP_VECTOR, and MisalignOut pulses high for exactly the next cycle.
  - Mode 7 is never misaligned.
- FlushOut = ValidIn & taken, combinational, in the same cycle as the decision. It is independent of StallIn.
- Next-PC priority at each rising edge:
  1. StallIn=1 and taken: PC holds; the effective target is written into the pending register and the pending flag is set.
  2. StallIn=1 and not taken: PC holds; existing pending state is kept.
  3. StallIn=0 and taken: PC loads the effective target; pending is cleared (a new redirect overrides an older pending one).
  4. StallIn=0, pending set: PC loads the pending target; pending is cleared.
  5. Otherwise: PC loads the sequential address.
- Latency: a redirect decided in cycle N appears on PCOut in cycle N+1, or in the first cycle after StallIn falls.
- Back-to-back taken decisions in consecutive cycles: the later one wins. FlushOut is high in both cycles.
- Reset asserted mid-stall discards the pending redirect.

Optional Feature:
- Macro: NEXT_PC_PERF_CNT_EN.
- Defined:
  - TakenCountOut increments by 1 on every rising edge where FlushOut=1, including stalled cycles and misaligned targets.
  - Saturates at 16'hFFFF.
  - Reset to 0 asynchronously.
- Undefined: TakenCountOut tied to 0; no counter flops are instantiated.

Test Plan:
- Reset then run, no stall, ValidIn=0 -> PCOut 0x0, 0x4, 0x8, 0xC on successive cycles; FlushOut=0.
- At PC=0x10: SelectorIn=2, ZeroIn=1, PCRelAddrIn=0x40 -> FlushOut=1 in that cycle; next PCOut=0x40. Repeat with ZeroIn=0 -> PCOut=0x14.
- SelectorIn=4, RegRelAddrIn=0x83 -> PCOut=0x82 is misaligned, so PCOut=0x100 and MisalignOut pulses for one cycle.
- SelectorIn=3, PCRelAddrIn=0x200 with StallIn=1 for 3 cycles -> FlushOut=1 in the decision cycle only; PCOut holds; PCOut=0x200 the cycle after StallIn falls.
- Selector codes 5 and 6 exercised with all four LessIn/ZeroIn combinations -> taken only for bne with Zero=0 and bge with Less=0. Code 7 -> PCOut=RESET_VECTOR.
- With NEXT_PC_PERF_CNT_EN defined: 70000 consecutive taken jal -> TakenCountOut saturates at 0xFFFF. Reset pulse mid-run -> PCOut=0x0 and counter=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// Bundle between the EXMA pipeline register, the hazard unit and fetch,
// as seen by the next-PC unit.
interface next_pc_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              StallIn;
  logic              ValidIn;
  logic [2:0]        SelectorIn;
  logic              LessIn;
  logic              ZeroIn;
  logic [ADDR_W-1:0] PCRelAddrIn;
  logic [ADDR_W-1:0] RegRelAddrIn;
  logic [ADDR_W-1:0] PCOut;
  logic              FlushOut;
  logic              MisalignOut;
  logic [15:0]       TakenCountOut;

  modport master (
    output StallIn, ValidIn, SelectorIn, LessIn, ZeroIn, PCRelAddrIn, RegRelAddrIn,
    input  PCOut, FlushOut, MisalignOut, TakenCountOut
  );

  modport slave (
    input  StallIn, ValidIn, SelectorIn, LessIn, ZeroIn, PCRelAddrIn, RegRelAddrIn,
    output PCOut, FlushOut, MisalignOut, TakenCountOut
  );
endinterface

// File: rtl/next_pc_unit.sv
// PC register and next-fetch-address selection with stall-held redirects and misaligned-target trap.
// Optional taken-redirect counter enabled by defining NEXT_PC_PERF_CNT_EN.
module next_pc_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned       INSTR_BYTES  = 4
) (
  input logic           clk,
  input logic           rst_n,
  next_pc_unit_if.slave io_npc
);

  typedef enum logic [2:0] {
    SelSeq, SelBlt, SelBeq, SelJal, SelJalr, SelBne, SelBge, SelSoftRst
  } sel_e;

  sel_e              w_sel;
  logic              w_taken;
  logic              w_soft_rst;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_eff_target;
  logic [ADDR_W-1:0] w_pc_d;
  logic              w_pend_d;
  logic [ADDR_W-1:0] w_pend_tgt_d;

  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_misalign;

  assign w_sel = sel_e'(io_npc.SelectorIn);

  always_comb begin
    w_taken    = 1'b0;
    w_soft_rst = 1'b0;
    w_target   = io_npc.PCRelAddrIn;
    if (io_npc.ValidIn) begin
      unique case (w_sel)
        SelSeq:  w_taken = 1'b0;
        SelBlt:  w_taken = io_npc.LessIn;
        SelBeq:  w_taken = io_npc.ZeroIn;
        SelJal:  w_taken = 1'b1;
        SelJalr: begin
          w_taken  = 1'b1;
          w_target = {io_npc.RegRelAddrIn[ADDR_W-1:1], 1'b0};
        end
        SelBne:  w_taken = !io_npc.ZeroIn;
        SelBge:  w_taken = !io_npc.LessIn;
        SelSoftRst: begin
          w_taken    = 1'b1;
          w_soft_rst = 1'b1;
          w_target   = RESET_VECTOR;
        end
      endcase
    end
  end

  // The soft-reset vector is trusted and bypasses the alignment check.
  assign w_misalign   = w_taken && !w_soft_rst &&
                        ((w_target % ADDR_W'(INSTR_BYTES)) != '0);
  assign w_eff_target = w_misalign ? TRAP_VECTOR : w_target;

  always_comb begin
    w_pc_d       = r_pc + ADDR_W'(INSTR_BYTES);
    w_pend_d     = r_pend;
    w_pend_tgt_d = r_pend_tgt;
    if (io_npc.StallIn) begin
      w_pc_d = r_pc;
      if (w_taken) begin
        w_pend_d     = 1'b1;
        w_pend_tgt_d = w_eff_target;
      end
    end else if (w_taken) begin
      w_pc_d   = w_eff_target;
      w_pend_d = 1'b0;
    end else if (r_pend) begin
      w_pc_d   = r_pend_tgt;
      w_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_d;
      r_pend     <= w_pend_d;
      r_pend_tgt <= w_pend_tgt_d;
      r_misalign <= w_misalign;
    end
  end

  assign io_npc.PCOut       = r_pc;
  assign io_npc.FlushOut    = rst_n && w_taken;
  assign io_npc.MisalignOut = r_misalign;

`ifdef NEXT_PC_PERF_CNT_EN
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
    end else if (io_npc.FlushOut && (r_taken_cnt != 16'hFFFF)) begin
      r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign io_npc.TakenCountOut = r_taken_cnt;
`else
  assign io_npc.TakenCountOut = '0;
`endif

endmodule
